// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM states, Q-phase
// markers and the per-state decode of the decoder control strobes.
package interrupt_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENT1 = 2'd1,
    ST_ENT2 = 2'd2
  } state_e;

  localparam logic [1:0]  Q_PUSH     = 2'd1;
  localparam logic [1:0]  Q_LAST     = 2'd3;
  localparam logic [12:0] DEF_VECTOR = 13'h004;

  typedef struct packed {
    logic dec_hold;
    logic instr_flush;
    logic stack_push;
    logic pc_vec_load;
    logic int_active;
  } seq_ctl_t;

  // ENT1 discards the fetched word; ENT2 pushes the PC at Q1 and vectors at Q3.
  function automatic seq_ctl_t ctl_decode(state_e st, logic [1:0] q);
    seq_ctl_t c;
    c = '0;
    case (st)
      ST_ENT1: begin
        c.dec_hold    = 1'b1;
        c.int_active  = 1'b1;
        c.instr_flush = (q == Q_LAST);
      end
      ST_ENT2: begin
        c.dec_hold    = 1'b1;
        c.int_active  = 1'b1;
        c.stack_push  = (q == Q_PUSH);
        c.pc_vec_load = (q == Q_LAST);
        c.instr_flush = (q == Q_LAST);
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Decoder/CPU-side bundle of the interrupt sequencer. The slave modport is the
// sequencer itself; the master modport is the decoder/core that drives it.
interface interrupt_sequencer_if #(
  parameter int NUM_SRC  = 4,
  parameter int PC_WIDTH = 13
);
  logic [1:0]          q_count;
  logic                instr_done;
  logic [NUM_SRC-1:0]  int_src;
  logic [NUM_SRC-1:0]  int_en;
  logic [NUM_SRC-1:0]  flag_clr;
  logic                gie_wr_en;
  logic                gie_wr_data;
  logic                retfie_exec;
  logic                dec_hold;
  logic                instr_flush;
  logic                stack_push;
  logic                pc_vec_load;
  logic [PC_WIDTH-1:0] pc_vec;
  logic                gie;
  logic [NUM_SRC-1:0]  int_flags;
  logic                int_active;

  modport master (
    output q_count, instr_done, int_src, int_en, flag_clr,
           gie_wr_en, gie_wr_data, retfie_exec,
    input  dec_hold, instr_flush, stack_push, pc_vec_load, pc_vec,
           gie, int_flags, int_active
  );

  modport slave (
    input  q_count, instr_done, int_src, int_en, flag_clr,
           gie_wr_en, gie_wr_data, retfie_exec,
    output dec_hold, instr_flush, stack_push, pc_vec_load, pc_vec,
           gie, int_flags, int_active
  );
endinterface

// File: rtl/interrupt_sequencer_int_flag_reg.sv
// One interrupt source: rising-edge detect feeding a sticky flag where a new
// edge beats a software clear arriving in the same clock.
module int_flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  input  logic clr_i,
  output logic flag_o
);
  logic src_q, flag_q, flag_d;

  assign flag_d = (src_i & ~src_q) | (flag_q & ~clr_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      src_q  <= src_i;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;
endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: latches source flags, owns GIE and forces a two
// instruction-cycle CALL to VECTOR when an enabled flag is pending at a boundary.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int                  NUM_SRC  = 4,
  parameter int                  PC_WIDTH = 13,
  parameter logic [PC_WIDTH-1:0] VECTOR   = PC_WIDTH'(DEF_VECTOR)
) (
  input logic                  clk,
  input logic                  rst,
  interrupt_sequencer_if.slave bus
);
  logic [NUM_SRC-1:0] flags;
  state_e             state_q, state_d;
  logic               gie_q, gie_d;
  logic               boundary, take;
  seq_ctl_t           ctl;

  int_flag_reg u_flag [NUM_SRC-1:0] (
    .clk   (clk),
    .rst   (rst),
    .src_i (bus.int_src),
    .clr_i (bus.flag_clr),
    .flag_o(flags)
  );

  assign boundary = bus.instr_done && (bus.q_count == Q_LAST);
  assign take     = gie_q && |(flags & bus.int_en);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Entry states advance on Q3 only, so each spans one full instruction cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (boundary && take)        state_d = ST_ENT1;
      ST_ENT1: if (bus.q_count == Q_LAST)   state_d = ST_ENT2;
      ST_ENT2: if (bus.q_count == Q_LAST)   state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl = ctl_decode(state_q, bus.q_count);
  end

  // Entry clear outranks software writes, which outrank RETFIE.
  always_comb begin
    gie_d = gie_q;
    if (state_q == ST_ENT2 && bus.q_count == Q_PUSH) gie_d = 1'b0;
    else if (bus.gie_wr_en)                          gie_d = bus.gie_wr_data;
    else if (bus.retfie_exec)                        gie_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) gie_q <= 1'b0;
    else     gie_q <= gie_d;
  end

  assign bus.dec_hold    = ctl.dec_hold;
  assign bus.instr_flush = ctl.instr_flush;
  assign bus.stack_push  = ctl.stack_push;
  assign bus.pc_vec_load = ctl.pc_vec_load;
  assign bus.int_active  = ctl.int_active;
  assign bus.pc_vec      = VECTOR;
  assign bus.gie         = gie_q;
  assign bus.int_flags   = flags;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios then random traffic, every
// cycle compared against a cycle-count model of the entry sequence.
module tb_interrupt_sequencer;
  localparam int          NUM_SRC  = 4;
  localparam int          PC_WIDTH = 13;
  localparam logic [12:0] VECTOR   = 13'h004;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interrupt_sequencer_if #(.NUM_SRC(NUM_SRC), .PC_WIDTH(PC_WIDTH)) bus ();

  interrupt_sequencer #(.NUM_SRC(NUM_SRC), .PC_WIDTH(PC_WIDTH), .VECTOR(VECTOR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // model: ent_cnt = 0 idle, k = k-th clock of the 8-clock entry
  int          ent_cnt, checks, failures, cyc_n, bnd_cyc, push_cyc, load_cyc;
  int          hold_cnt, push_cnt, h0, p0, k;
  logic        m_gie;
  logic [3:0]  m_flags, m_prev;
  logic [1:0]  q;
  logic [12:0] pc_m, pushed_pc, jmp_tgt;
  bit          jmp_en, spurious;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [22:0] obs, exp;
    logic        take, busy, load_seen;
    bus.q_count    = q;
    bus.instr_done = (q == 2'd3 && ent_cnt == 0) ||
                     (spurious && q != 2'd3 && $urandom_range(0, 3) == 0);
    @(negedge clk);
    exp = {ent_cnt > 0, ent_cnt == 4 || ent_cnt == 8, ent_cnt == 6, ent_cnt == 8,
           ent_cnt > 0, m_gie, m_flags, VECTOR};
    obs = {bus.dec_hold, bus.instr_flush, bus.stack_push, bus.pc_vec_load,
           bus.int_active, bus.gie, bus.int_flags, bus.pc_vec};
    check("cycle_outputs", 32'(obs), 32'(exp));
    load_seen = bus.pc_vec_load;
    if (bus.stack_push) begin push_cyc = cyc_n; push_cnt++; pushed_pc = pc_m; end
    if (bus.pc_vec_load) load_cyc = cyc_n;
    if (bus.dec_hold) hold_cnt++;
    @(posedge clk);
    if (rst) begin
      ent_cnt = 0; m_gie = 1'b0; m_flags = '0; m_prev = '0;
    end else begin
      busy = (ent_cnt != 0);
      take = !busy && bus.instr_done && q == 2'd3 && m_gie && |(m_flags & bus.int_en);
      if (bus.instr_done && q == 2'd3 && !busy) pc_m = jmp_en ? jmp_tgt : pc_m + 13'd1;
      if (load_seen) pc_m = VECTOR;
      if (ent_cnt == 6)          m_gie = 1'b0;
      else if (bus.gie_wr_en)    m_gie = bus.gie_wr_data;
      else if (bus.retfie_exec)  m_gie = 1'b1;
      m_flags = (bus.int_src & ~m_prev) | (m_flags & ~bus.flag_clr);
      m_prev  = bus.int_src;
      if (take) begin ent_cnt = 1; bnd_cyc = cyc_n; end
      else if (ent_cnt == 8) ent_cnt = 0;
      else if (ent_cnt > 0)  ent_cnt++;
    end
    #1;
    q++;
    cyc_n++;
    bus.flag_clr    = '0;
    bus.gie_wr_en   = 1'b0;
    bus.retfie_exec = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_hold(input string tag, input int maxc);
    int n;
    n = 0;
    while (!bus.dec_hold && n < maxc) begin step(); n++; end
    check(tag, 32'(bus.dec_hold), 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0; cyc_n = 0; bnd_cyc = 0; push_cyc = 0; load_cyc = 0;
    hold_cnt = 0; push_cnt = 0; jmp_en = 0; spurious = 0; jmp_tgt = '0; pc_m = '0;
    pushed_pc = '0;
    rst = 1'b1; q = 2'd0;
    bus.q_count = 2'd0; bus.instr_done = 1'b0; bus.int_src = '0; bus.int_en = '0;
    bus.flag_clr = '0; bus.gie_wr_en = 1'b0; bus.gie_wr_data = 1'b0; bus.retfie_exec = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ent_cnt = 0; m_gie = 1'b0; m_flags = '0; m_prev = '0;
    check("reset_strobes", 32'({bus.dec_hold, bus.instr_flush, bus.stack_push,
                                bus.pc_vec_load, bus.int_active}), 32'd0);
    check("reset_gie", 32'(bus.gie), 32'd0);
    check("reset_flags", 32'(bus.int_flags), 32'd0);
    check("reset_pc_vec", 32'(bus.pc_vec), 32'h004);
    rst = 1'b0;

    // 1: basic entry and latency
    bus.gie_wr_en = 1'b1; bus.gie_wr_data = 1'b1; step();
    bus.int_en = 4'b0001; bus.int_src[0] = 1'b1; step();
    wait_hold("t1_entry", 12);
    run(9);
    check("t1_push_lat", 32'(push_cyc - bnd_cyc), 32'd6);
    check("t1_load_lat", 32'(load_cyc - bnd_cyc), 32'd8);
    check("t1_gie_cleared", 32'(bus.gie), 32'd0);

    // 2: gie off blocks entry; write enables it
    h0 = hold_cnt;
    run(80);
    check("t2_no_entry_gie0", 32'(hold_cnt - h0), 32'd0);
    p0 = push_cnt;
    bus.gie_wr_en = 1'b1; bus.gie_wr_data = 1'b1; step();
    wait_hold("t2_entry_after_gie", 8);
    run(9);
    check("t2_pushed", 32'(push_cnt - p0), 32'd1);

    // 3: set wins over clear
    bus.flag_clr = 4'b0001; step();
    bus.int_src[1] = 1'b1; bus.flag_clr[1] = 1'b1; step();
    check("t3_set_wins", 32'(bus.int_flags[1]), 32'd1);
    check("t3_clr0", 32'(bus.int_flags[0]), 32'd0);

    // 4: RETFIE re-entry, then no re-entry once flag cleared
    bus.int_en = 4'b0010; bus.retfie_exec = 1'b1; step();
    check("t4_retfie_gie", 32'(bus.gie), 32'd1);
    wait_hold("t4_reentry", 8);
    run(9);
    bus.flag_clr = 4'b0010; step();
    bus.retfie_exec = 1'b1; step();
    h0 = hold_cnt;
    run(20);
    check("t4_no_reentry", 32'(hold_cnt - h0), 32'd0);
    check("t4_gie_set", 32'(bus.gie), 32'd1);

    // 5: reset at ENT2 q=0 aborts without push
    bus.int_src = '0; step();
    bus.int_en = 4'b0100; bus.int_src[2] = 1'b1; step();
    k = 0;
    while (ent_cnt != 5 && k < 20) begin step(); k++; end
    check("t5_reach_ent2", 32'(bus.dec_hold), 32'd1);
    p0 = push_cnt; h0 = load_cyc;
    rst = 1'b1; bus.int_src = '0; step();
    rst = 1'b0;
    run(20);
    check("t5_no_push", 32'(push_cnt - p0), 32'd0);
    check("t5_no_load", 32'(load_cyc - h0), 32'd0);
    check("t5_gie", 32'(bus.gie), 32'd0);
    check("t5_flags", 32'(bus.int_flags), 32'd0);

    // 6: take on a GOTO 0x123 boundary
    jmp_tgt = 13'h123; jmp_en = 1;
    bus.int_en = 4'b0001; bus.gie_wr_en = 1'b1; bus.gie_wr_data = 1'b1; step();
    bus.int_src[0] = 1'b1; step();
    h0 = hold_cnt;
    wait_hold("t6_entry", 8);
    run(10);
    jmp_en = 0;
    check("t6_pushed_pc", 32'(pushed_pc), 32'h123);
    check("t6_hold_len", 32'(hold_cnt - h0), 32'd8);

    // random traffic, spurious instr_done at non-Q3 phases
    spurious = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) bus.int_src = bus.int_src ^ 4'($urandom_range(1, 15));
      if ($urandom_range(0, 20) == 0) bus.int_en = 4'($urandom);
      if ($urandom_range(0, 12) == 0) bus.flag_clr = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        bus.gie_wr_en = 1'b1; bus.gie_wr_data = 1'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bus.retfie_exec = 1'b1;
      rst = ($urandom_range(0, 200) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
